// File: rtl/samp_lane_arbiter.sv
// samp_lane_arbiter: round-robin burst arbiter sharing one sample-test stage between two raster lanes
// Ports: clk, rst (async active-low); per-lane R16 beats tri/color/sample + validSamp_R16H in, ready_R16H out;
// registered R17 beat tri/color/sample + validSamp_R17H + lane_R17H out, ready_R17H in;
// grant_cnt0/grant_cnt1/conflict_cnt perf counters, live only when SAMP_ARB_PERF_CNT_EN is defined.
module samp_lane_arbiter #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int BURST  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [1:0][SIGFIG*VERTS*AXIS-1:0]    tri_R16S,
    input  logic [1:0][SIGFIG*COLORS-1:0]        color_R16U,
    input  logic [1:0][SIGFIG*2-1:0]             sample_R16S,
    input  logic [1:0]                           validSamp_R16H,
    output logic [1:0]                           ready_R16H,
    output logic [SIGFIG*VERTS*AXIS-1:0]         tri_R17S,
    output logic [SIGFIG*COLORS-1:0]             color_R17U,
    output logic [SIGFIG*2-1:0]                  sample_R17S,
    output logic                                 validSamp_R17H,
    output logic                                 lane_R17H,
    input  logic                                 ready_R17H,
    output logic [15:0]                          grant_cnt0,
    output logic [15:0]                          grant_cnt1,
    output logic [15:0]                          conflict_cnt
);
    localparam int BW = $clog2(BURST) + 1;
    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;
    state_t          r_state, w_nstate;
    logic [BW-1:0]   r_bcnt, w_nbcnt;
    logic            r_pri, w_npri;
    logic            w_load_en, w_gnt, w_sel, w_k;
    logic [1:0]      w_v;
    assign w_load_en = !validSamp_R17H || ready_R17H;
    assign w_v       = validSamp_R16H;
    assign w_k       = (r_state == HOLD1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_pri   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_bcnt  <= w_nbcnt;
            r_pri   <= w_npri;
        end
    end
    always_comb begin
        w_nstate = r_state;
        w_nbcnt  = r_bcnt;
        w_npri   = r_pri;
        w_gnt    = 1'b0;
        w_sel    = 1'b0;
        if (w_load_en) begin
            if (r_state == IDLE) begin
                if (|w_v) begin
                    w_gnt   = 1'b1;
                    w_sel   = w_v[r_pri] ? r_pri : !r_pri;
                    w_nbcnt = BW'(1);
                end
            end else if (w_v[w_k] && r_bcnt < BW'(BURST)) begin
                w_gnt   = 1'b1;
                w_sel   = w_k;
                w_nbcnt = r_bcnt + BW'(1);
            end else if (w_v[!w_k]) begin
                w_gnt   = 1'b1;
                w_sel   = !w_k;
                w_nbcnt = BW'(1);
            end else if (w_v[w_k]) begin
                // burst exhausted but nobody else is waiting: restart it
                w_gnt   = 1'b1;
                w_sel   = w_k;
                w_nbcnt = BW'(1);
            end else begin
                // lanes went quiet: the last owner gives up priority
                w_nstate = IDLE;
                w_npri   = !w_k;
                w_nbcnt  = '0;
            end
            if (w_gnt) w_nstate = w_sel ? HOLD1 : HOLD0;
        end
    end
    // rst gate keeps lanes from seeing an accept while the block is held in reset
    always_comb ready_R16H = {w_gnt && w_sel && rst, w_gnt && !w_sel && rst};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_R17S       <= '0;
            color_R17U     <= '0;
            sample_R17S    <= '0;
            validSamp_R17H <= 1'b0;
            lane_R17H      <= 1'b0;
        end else if (w_gnt) begin
            tri_R17S       <= tri_R16S[w_sel];
            color_R17U     <= color_R16U[w_sel];
            sample_R17S    <= sample_R16S[w_sel];
            validSamp_R17H <= 1'b1;
            lane_R17H      <= w_sel;
        end else if (ready_R17H) begin
            validSamp_R17H <= 1'b0;
        end
    end
`ifdef SAMP_ARB_PERF_CNT_EN
    logic [15:0] r_g0, r_g1, r_cf;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_g0 <= '0;
            r_g1 <= '0;
            r_cf <= '0;
        end else begin
            if (ready_R16H[0] && !(&r_g0)) r_g0 <= r_g0 + 16'd1;
            if (ready_R16H[1] && !(&r_g1)) r_g1 <= r_g1 + 16'd1;
            if ((&w_v) && w_load_en && !(&r_cf)) r_cf <= r_cf + 16'd1;
        end
    end
    assign grant_cnt0   = r_g0;
    assign grant_cnt1   = r_g1;
    assign conflict_cnt = r_cf;
`else
    assign grant_cnt0   = '0;
    assign grant_cnt1   = '0;
    assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_samp_lane_arbiter.sv
// tb_samp_lane_arbiter: randomized scoreboard bench for samp_lane_arbiter
module tb_samp_lane_arbiter;
    localparam int SIGFIG = 24, VERTS = 3, AXIS = 3, COLORS = 3, BURST = 4;
    localparam int TW = SIGFIG*VERTS*AXIS, CW = SIGFIG*COLORS, SW = SIGFIG*2;
`ifdef SAMP_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic                clk = 1'b0;
    logic                rst;
    logic [1:0][TW-1:0]  tri_R16S;
    logic [1:0][CW-1:0]  color_R16U;
    logic [1:0][SW-1:0]  sample_R16S;
    logic [1:0]          validSamp_R16H, ready_R16H;
    logic [TW-1:0]       tri_R17S;
    logic [CW-1:0]       color_R17U;
    logic [SW-1:0]       sample_R17S;
    logic                validSamp_R17H, lane_R17H, ready_R17H;
    logic [15:0]         grant_cnt0, grant_cnt1, conflict_cnt;
    samp_lane_arbiter #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .tri_R16S(tri_R16S), .color_R16U(color_R16U), .sample_R16S(sample_R16S),
        .validSamp_R16H(validSamp_R16H), .ready_R16H(ready_R16H),
        .tri_R17S(tri_R17S), .color_R17U(color_R17U), .sample_R17S(sample_R17S),
        .validSamp_R17H(validSamp_R17H), .lane_R17H(lane_R17H), .ready_R17H(ready_R17H),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic          lane;
        logic [TW-1:0] t;
        logic [CW-1:0] c;
        logic [SW-1:0] s;
    } beat_t;
    beat_t q[$];
    int n_chk = 0, n_fail = 0;
    // reference: who owns the datapath, how long they've had it, who is favoured when idle
    bit        m_idle = 1'b1, m_owner = 1'b0, m_pri = 1'b0, m_ov = 1'b0;
    int        m_run = 0;
    int        m_g0 = 0, m_g1 = 0, m_cf = 0;
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    // model: expected acceptance, output occupancy and counters, evaluated mid-cycle
    always @(negedge clk) begin
        logic [1:0] v, er;
        bit le, w;
        beat_t b;
        if (!rst) begin
            m_idle = 1'b1; m_owner = 1'b0; m_pri = 1'b0; m_ov = 1'b0; m_run = 0;
            m_g0 = 0; m_g1 = 0; m_cf = 0;
            q.delete();
            chk("rst_ready_R16H", 256'(ready_R16H), 256'(0));
            chk("rst_validSamp_R17H", 256'(validSamp_R17H), 256'(0));
        end else begin
            chk("validSamp_R17H", 256'(validSamp_R17H), 256'(m_ov));
            le = !m_ov || ready_R17H;
            v  = validSamp_R16H;
            er = 2'b00;
            if (le) begin
                if (v == 2'b11 && PERF && m_cf < 65535) m_cf++;
                if (v == 2'b00) begin
                    if (!m_idle) m_pri = !m_owner;
                    m_idle = 1'b1;
                end else begin
                    if (m_idle) begin
                        w = v[m_pri] ? m_pri : !m_pri;
                        m_run = 1;
                    end else if (v[m_owner] && m_run < BURST) begin
                        w = m_owner;
                        m_run++;
                    end else if (v[!m_owner]) begin
                        w = !m_owner;
                        m_run = 1;
                    end else begin
                        w = m_owner;
                        m_run = 1;
                    end
                    m_idle = 1'b0;
                    m_owner = w;
                    er[w] = 1'b1;
                end
            end
            chk("ready_R16H", 256'(ready_R16H), 256'(er));
            if (er != 2'b00) begin
                b.lane = er[1];
                b.t = tri_R16S[er[1]];
                b.c = color_R16U[er[1]];
                b.s = sample_R16S[er[1]];
                q.push_back(b);
                m_ov = 1'b1;
                if (PERF && er[0] && m_g0 < 65535) m_g0++;
                if (PERF && er[1] && m_g1 < 65535) m_g1++;
            end else if (ready_R17H) begin
                m_ov = 1'b0;
            end
        end
    end
    // monitor: each beat consumed downstream must be the oldest expected one
    always @(negedge clk) begin
        beat_t e;
        if (rst && validSamp_R17H && ready_R17H) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got lane %0d with empty scoreboard at %0t", lane_R17H, $time);
            end else begin
                e = q.pop_front();
                chk("lane_R17H", 256'(lane_R17H), 256'(e.lane));
                chk("tri_R17S", 256'(tri_R17S), 256'(e.t));
                chk("color_R17U", 256'(color_R17U), 256'(e.c));
                chk("sample_R17S", 256'(sample_R17S), 256'(e.s));
            end
        end
    end
    task automatic step(input int p0, input int p1, input int pr);
        logic [255:0] r;
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            r = rnd(); tri_R16S[l] = r[TW-1:0];
            r = rnd(); color_R16U[l] = r[CW-1:0];
            r = rnd(); sample_R16S[l] = r[SW-1:0];
        end
        validSamp_R16H[0] = $urandom_range(99) < p0;
        validSamp_R16H[1] = $urandom_range(99) < p1;
        ready_R17H = $urandom_range(99) < pr;
    endtask
    task automatic chk_cnt();
        chk("grant_cnt0", 256'(grant_cnt0), 256'(m_g0));
        chk("grant_cnt1", 256'(grant_cnt1), 256'(m_g1));
        chk("conflict_cnt", 256'(conflict_cnt), 256'(m_cf));
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_validSamp_R17H"}, 256'(validSamp_R17H), 256'(0));
        chk({tag, "_lane_R17H"}, 256'(lane_R17H), 256'(0));
        chk({tag, "_tri_R17S"}, 256'(tri_R17S), 256'(0));
        chk({tag, "_color_R17U"}, 256'(color_R17U), 256'(0));
        chk({tag, "_sample_R17S"}, 256'(sample_R17S), 256'(0));
        chk({tag, "_ready_R16H"}, 256'(ready_R16H), 256'(0));
        chk({tag, "_grant_cnt0"}, 256'(grant_cnt0), 256'(0));
        chk({tag, "_grant_cnt1"}, 256'(grant_cnt1), 256'(0));
        chk({tag, "_conflict_cnt"}, 256'(conflict_cnt), 256'(0));
    endtask
    initial begin
        rst = 1'b0;
        tri_R16S = '0; color_R16U = '0; sample_R16S = '0;
        validSamp_R16H = 2'b11;
        ready_R17H = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        validSamp_R16H = 2'b00;
        repeat (10) step(100, 0, 100);
        repeat (2) step(0, 0, 100);
        if (PERF) chk("lane0_only_grants", 256'(grant_cnt0), 256'(10));
        chk_cnt();
        repeat (40) step(100, 100, 100);
        repeat (60) step(100, 100, 50);
        repeat (2) step(100, 0, 100);
        repeat (2) step(0, 0, 100);
        repeat (6) step(100, 100, 100);
        repeat (3000) step(70, 70, 70);
        repeat (2) step(0, 0, 100);
        chk_cnt();
        repeat (3) step(0, 100, 100);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 256'(validSamp_R17H), 256'(1));
        rst = 1'b0;
        #1;
        chk_zero("midburst_rst");
        repeat (2) @(posedge clk);
        #1;
        validSamp_R16H = 2'b11;
        ready_R17H = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_first_grant", 256'(ready_R16H), 256'(2'b01));
        repeat (8) step(100, 100, 100);
        repeat (3) step(0, 0, 100);
        chk_cnt();
        chk("scoreboard_drained", 256'(q.size()), 256'(0));
`ifdef SAMP_ARB_PERF_CNT_EN
        repeat (70000) step(0, 100, 100);
        repeat (2) step(0, 0, 100);
        chk("grant_cnt1_saturated", 256'(grant_cnt1), 256'(16'hFFFF));
        chk_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
